mem_access_unit: RTL and testbench

Memory-access half of the EX/MEM stage. Sits directly upstream of the EX/MEM→WB pipeline register and drives its data and ENABLE inputs. ALU-only instructions pass through combinationally. Loads and stores run a request/acknowledge transaction on the data-memory bus, with a timeout. The unit stalls the front of the pipeline until the access completes, then presents the loaded word as `out_PR`.

---
 rtl/mem_access_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bundles the instruction-in, data-memory bus and downstream-register signals of mem_access_unit.
// The unit connects through slave; the pipeline/memory environment connects through master.
interface mem_access_if;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [3:0]  in_WC;
  logic [31:0] in_PC;
  logic [31:0] in_alu_res;
  logic [31:0] in_store_data;
  logic [1:0]  in_S_MXRB;
  logic        in_W_RB;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_enable;
  logic [3:0]  out_WC;
  logic [31:0] out_PC;
  logic [31:0] out_alu_res;
  logic [1:0]  out_S_MXRB;
  logic        out_W_RB;
  logic [31:0] out_PR;
  logic        bus_error;

  modport master (
    output in_valid, in_mem_read, in_mem_write, in_WC, in_PC, in_alu_res,
           in_store_data, in_S_MXRB, in_W_RB, mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, out_enable, out_WC,
           out_PC, out_alu_res, out_S_MXRB, out_W_RB, out_PR, bus_error
  );

  modport slave (
    input  in_valid, in_mem_read, in_mem_write, in_WC, in_PC, in_alu_res,
           in_store_data, in_S_MXRB, in_W_RB, mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, out_enable, out_WC,
           out_PC, out_alu_res, out_S_MXRB, out_W_RB, out_PR, bus_error
  );
endinterface

// File: rtl/mem_access_unit.sv
// EX/MEM memory-access stage: ALU ops pass through combinationally, loads/stores run a
// req/ack bus access with timeout while stalling upstream; sticky bus_error on timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic         CLK,
  input logic         RESET,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_BUSY = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [3:0]  wc_q, wc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  smx_q, smx_d;
  logic        wrb_q, wrb_d;
  logic [31:0] pr_q, pr_d;

  logic is_mem, pass, accept;

  always_comb begin
    is_mem = bus.in_mem_read | bus.in_mem_write;
    pass   = !RESET && (state_q == IDLE) && bus.in_valid && !is_mem;
    accept = (state_q == IDLE) && bus.in_valid && is_mem;
  end

  // Downstream fields: live inputs for a pass-through, otherwise the latched instruction.
  always_comb begin
    bus.stall      = !RESET && (accept || (state_q == BUSY));
    bus.out_enable = pass || (!RESET && (state_q == DONE));
    if (pass) begin
      bus.out_WC      = bus.in_WC;
      bus.out_PC      = bus.in_PC;
      bus.out_alu_res = bus.in_alu_res;
      bus.out_S_MXRB  = bus.in_S_MXRB;
      bus.out_W_RB    = bus.in_W_RB;
      bus.out_PR      = '0;
    end else begin
      bus.out_WC      = wc_q;
      bus.out_PC      = pc_q;
      bus.out_alu_res = addr_q;
      bus.out_S_MXRB  = smx_q;
      bus.out_W_RB    = wrb_q;
      bus.out_PR      = pr_q;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.bus_error = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    wc_d    = wc_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    smx_d   = smx_q;
    wrb_d   = wrb_q;
    pr_d    = pr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wc_d    = bus.in_WC;
          pc_d    = bus.in_PC;
          addr_d  = bus.in_alu_res;
          wdata_d = bus.in_store_data;
          smx_d   = bus.in_S_MXRB;
          wrb_d   = bus.in_W_RB;
          we_d    = bus.in_mem_write;
          pr_d    = '0;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the final allowed cycle still completes normally.
        if (bus.mem_ack) begin
          pr_d    = we_q ? 32'd0 : bus.mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST_BUSY) begin
          pr_d    = '0;
          wrb_d   = 1'b0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      smx_q   <= '0;
      wrb_q   <= 1'b0;
      pr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      smx_q   <= smx_d;
      wrb_q   <= wrb_d;
      pr_q    <= pr_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: each instruction's cycle-by-cycle trace is predicted
// from its ack latency and the timeout limit, then compared on the falling edge.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   miscompares = 0;
  bit   err_model = 1'b0;

  mem_access_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid      = 1'b0;
      bus.in_mem_read   = 1'($urandom);
      bus.in_mem_write  = 1'($urandom);
      bus.in_alu_res    = $urandom;
      bus.mem_ack       = 1'($urandom);
      bus.mem_rdata     = $urandom;
      @(negedge clk);
      check("idle_enable", 32'(bus.out_enable), 32'd0);
      check("idle_stall",  32'(bus.stall), 32'd0);
      check("idle_req",    32'(bus.mem_req), 32'd0);
      check("idle_err",    32'(bus.bus_error), 32'(err_model));
      next_cycle();
    end
    bus.mem_ack = 1'b0;
  endtask

  // k = BUSY cycle carrying the ack (1-based); any k outside 1..TO means no ack in time.
  task automatic run_instr(input bit rd, input bit wr, input int k,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdat);
    logic [3:0] wc  = 4'($urandom);
    logic [31:0] pc = $urandom;
    logic [1:0] smx = 2'($urandom);
    logic wrb       = 1'($urandom);
    bit mem         = rd | wr;
    bit tmo         = mem && !(k >= 1 && k <= TO);
    int eff         = tmo ? TO : k;
    int last        = mem ? eff + 1 : 0;
    logic [31:0] exp_pr = (!mem || wr || tmo) ? 32'd0 : rdat;
    bus.in_valid      = 1'b1;
    bus.in_mem_read   = rd;
    bus.in_mem_write  = wr;
    bus.in_WC         = wc;
    bus.in_PC         = pc;
    bus.in_alu_res    = addr;
    bus.in_store_data = sdata;
    bus.in_S_MXRB     = smx;
    bus.in_W_RB       = wrb;
    for (int c = 0; c <= last; c++) begin
      bus.mem_ack   = mem ? (c == k) : 1'($urandom);
      bus.mem_rdata = (mem && c == k) ? rdat : $urandom;
      @(negedge clk);
      if (c == last) begin
        if (tmo) err_model = 1'b1;
        check("out_enable", 32'(bus.out_enable), 32'd1);
        check("stall_done", 32'(bus.stall), 32'd0);
        check("req_done",   32'(bus.mem_req), 32'd0);
        check("out_WC",     32'(bus.out_WC), 32'(wc));
        check("out_PC",     bus.out_PC, pc);
        check("out_alu",    bus.out_alu_res, addr);
        check("out_smx",    32'(bus.out_S_MXRB), 32'(smx));
        check("out_W_RB",   32'(bus.out_W_RB), 32'(wrb & !tmo));
        check("out_PR",     bus.out_PR, exp_pr);
      end else begin
        check("stall",      32'(bus.stall), 32'd1);
        check("enable_off", 32'(bus.out_enable), 32'd0);
        check("mem_req",    32'(bus.mem_req), 32'(c != 0));
        if (c != 0) begin
          check("mem_we",   32'(bus.mem_we), 32'(wr));
          check("mem_addr", bus.mem_addr, addr);
          if (wr) check("mem_wdata", bus.mem_wdata, sdata);
        end
      end
      check("bus_error", 32'(bus.bus_error), 32'(err_model));
      next_cycle();
    end
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0;
    bus.in_WC = '0; bus.in_PC = '0; bus.in_alu_res = '0; bus.in_store_data = '0;
    bus.in_S_MXRB = '0; bus.in_W_RB = 1'b0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall",  32'(bus.stall), 32'd0);
    check("rst_req",    32'(bus.mem_req), 32'd0);
    check("rst_we",     32'(bus.mem_we), 32'd0);
    check("rst_enable", 32'(bus.out_enable), 32'd0);
    check("rst_err",    32'(bus.bus_error), 32'd0);
    check("rst_addr",   bus.mem_addr, 32'd0);
    check("rst_wdata",  bus.mem_wdata, 32'd0);
    check("rst_PR",     bus.out_PR, 32'd0);
    check("rst_PC",     bus.out_PC, 32'd0);
    check("rst_alu",    bus.out_alu_res, 32'd0);
    check("rst_WC",     32'(bus.out_WC), 32'd0);
    check("rst_smx",    32'(bus.out_S_MXRB), 32'd0);
    check("rst_wrb",    32'(bus.out_W_RB), 32'd0);
    next_cycle();

    run_instr(1'b0, 1'b0, 0, 32'h1234, $urandom, $urandom);        // ALU pass-through
    run_instr(1'b1, 1'b0, 3, 32'h100, $urandom, 32'hDEADBEEF);      // load, ack in 3rd BUSY
    run_instr(1'b0, 1'b1, 1, $urandom, 32'hA5A5A5A5, $urandom);     // store, immediate ack
    run_instr(1'b1, 1'b0, TO, $urandom, $urandom, 32'hCAFEF00D);    // ack/timeout collision
    run_instr(1'b1, 1'b1, 2, $urandom, $urandom, $urandom);         // read+write -> write
    run_instr(1'b1, 1'b0, 0, 32'h200, $urandom, $urandom);          // timeout
    idle(2);
    run_instr(1'b0, 1'b0, 0, $urandom, $urandom, $urandom);         // error stays sticky

    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 3);
      run_instr(kind == 1 || kind == 3, kind >= 2, $urandom_range(0, TO + 1),
                $urandom, $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // Reset in the 2nd BUSY cycle of a load, followed by a late ack.
    bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0;
    bus.in_alu_res = 32'h300; bus.mem_ack = 1'b0;
    @(negedge clk);
    check("mr_accept_stall", 32'(bus.stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("mr_busy_req", 32'(bus.mem_req), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_stall",  32'(bus.stall), 32'd0);
    check("mr_rst_enable", 32'(bus.out_enable), 32'd0);
    next_cycle();
    rst = 1'b0;
    err_model = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("mr_req",    32'(bus.mem_req), 32'd0);
    check("mr_stall",  32'(bus.stall), 32'd0);
    check("mr_err",    32'(bus.bus_error), 32'd0);
    check("mr_addr",   bus.mem_addr, 32'd0);
    next_cycle();
    bus.mem_ack = 1'b0;
    idle(1);
    run_instr(1'b0, 1'b0, 0, 32'h77, $urandom, $urandom);
    run_instr(1'b1, 1'b0, 2, 32'h400, $urandom, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
